gcd_requester: RTL and testbench
================================

# gcd_requester

Initiator-side sequencer for the GCD datapath core. It accepts operand pairs from an upstream producer into a small in-order queue and issues each pair to the core with a one-cycle `go_o` pulse. It waits for the core's `done_i`, captures the result, and returns it downstream over a valid/ready response channel. It also resolves zero-operand requests locally and flags any request the core fails to finish within a bounded number of cycles.

## Interface
- `WIDTH`, 4: operand and result width.
- `DEPTH`, 4: request queue entries (power of two, ≥2).
- `TIMEOUT`, 64: maximum WAIT cycles before a request is declared failed (≥2).

- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: upstream request valid.
- `req_ready` output 1: queue not full.
- `req_x`, `req_y` input WIDTH: operands.
- `go_o` output 1: start pulse to core.
- `x_o`, `y_o` output WIDTH: operands to core.
- `done_i` input 1: core completion strobe.
- `d_i` input WIDTH: core result.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: downstream accepts response.
- `rsp_d` output WIDTH: GCD result.
- `rsp_err` output 1: timeout flag.
- `busy` output 1: FSM not in IDLE, or queue non-empty.

## Operation
- **Queue.** FIFO of DEPTH `{x,y}` entries.
  - Push on `req_valid & req_ready`.
  - `req_ready = !full`, computed from the registered count only. There is no same-cycle pop bypass, so a full queue refuses a push even when a pop happens in the same cycle.
  - The head is popped only on the response handshake (`rsp_valid & rsp_ready`).
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Queue empty: stay.
  - Head has `x==0` or `y==0`: go to RESP with `rsp_d = x|y` (gcd(a,0)=a; gcd(0,0)=0) and `rsp_err=0`. The core is never started for these requests, because it does not terminate on zero operands.
  - Otherwise: go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `go_o=1`; `x_o`/`y_o` = head operands.
  - Go to WAIT and clear the timeout counter.
- **WAIT**
  - `x_o`/`y_o` held stable; `go_o=0`; counter increments once per cycle (1..TIMEOUT).
  - `done_i=1`: capture `d_i` into `rsp_d`, set `rsp_err=0`, go to RESP.
  - Counter equals TIMEOUT with `done_i=0`: set `rsp_d=0`, `rsp_err=1`, go to RESP.
  - `done_i` in the final cycle wins over timeout.
- **RESP**
  - `rsp_valid=1`; `rsp_d`/`rsp_err` held stable until the handshake.
  - On handshake: pop, go to IDLE.
- `done_i` outside WAIT is ignored. This includes late strobes from a timed-out request.
- Responses are returned strictly in request order.
- `x_o`/`y_o` hold their last issued value outside ISSUE/WAIT.

## Timing
- **Reset values:** `go_o=0`, `x_o=0`, `y_o=0`, `rsp_valid=0`, `rsp_d=0`, `rsp_err=0`, `busy=0`, `req_ready=1`. Queue is empty, counter is 0, FSM is in IDLE.
- **Request-to-core latency.** For a request accepted at edge N into an empty queue with the FSM in IDLE:
  - FSM enters ISSUE at edge N+1.
  - `go_o` is high for the single cycle between edges N+1 and N+2.
  - WAIT starts at edge N+2.
- **Result capture.** A `done_i` sampled at edge M puts `rsp_valid` high from edge M onward.
- **Zero-operand path.** Accepted at edge N gives `rsp_valid` high from edge N+1.
- **Timeout path.** `rsp_valid` rises on the edge that ends WAIT cycle TIMEOUT.
- **Back-to-back requests.** The next ISSUE occurs no earlier than the edge after the response handshake, so there is at most one request in flight.
- **Reset mid-operation.** Any state aborts to IDLE on the next edge. The queue and any in-flight request are discarded and all outputs return to their reset values. A `done_i` arriving after reset is ignored.
- All outputs are registered except `req_ready` and `busy`, which are combinational from registered state.

## Test plan
1. **Basic request.** Req (12,8); core model asserts `done_i` with `d_i=4` on the 5th WAIT cycle.
   - `go_o` is high exactly 1 cycle with `x_o=12`, `y_o=8`.
   - Response is `rsp_d=4`, `rsp_err=0`.
   - `x_o`/`y_o` stay stable throughout WAIT.
2. **Zero operands.** Reqs (0,9) then (0,0), with `rsp_ready=1`.
   - `go_o` never asserts.
   - Responses are 9 then 0, each 1 cycle after reaching the head.
3. **Backpressure.** `rsp_ready=0`; push 5 requests (6,4), (9,3), (7,7), (15,10), (8,12).
   - `req_ready` drops after the 4th accept; the 5th stalls.
   - Releasing `rsp_ready` yields responses 2, 3, 7, 5, 4 in order, and the 5th is accepted after the first pop.
4. **Timeout.** Core never asserts `done_i`.
   - `rsp_err=1` and `rsp_d=0` after exactly 64 WAIT cycles.
   - A `done_i` injected 3 cycles later is ignored and the next request proceeds normally.
   - `done_i` exactly on WAIT cycle 64 yields `rsp_err=0` with `d_i` captured.
5. **Reset mid-WAIT.** Assert `rst` one cycle during WAIT with 2 entries queued.
   - Next cycle: `go_o=0`, `rsp_valid=0`, `busy=0`, `req_ready=1`.
   - A subsequent `done_i` produces no response.
6. **Simultaneous pop and push on a full queue.** Handshake and `req_valid` arrive on the same edge.
   - The push is refused that cycle.
   - `req_ready=1` on the following cycle, and the push is accepted then.

Source files
------------

// File: rtl/gcd_requester.sv
// In-order request queue feeding a GCD core one pair at a time; zero operands resolved locally, stuck core flagged by timeout.
// ISSUE one edge after a request heads an idle queue; req_ready falls when full; a response is held until rsp_ready.
module gcd_requester #(
   parameter int WIDTH   = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_x,
   input  logic [WIDTH-1:0] req_y,
   output logic             go_o,
   output logic [WIDTH-1:0] x_o,
   output logic [WIDTH-1:0] y_o,
   input  logic             done_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_d,
   output logic             rsp_err,
   output logic             busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   typedef struct packed {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
   } req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   req_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          empty;
   logic          full;
   req_t          head;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] x_nxt;
   logic [WIDTH-1:0] y_nxt;
   logic [WIDTH-1:0] d_nxt;
   logic             err_nxt;

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign pop       = rsp_valid && rsp_ready;
   assign head      = mem[rd_ptr];
   assign busy      = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {req_x, req_y};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      x_nxt     = x_o;
      y_nxt     = y_o;
      d_nxt     = rsp_d;
      err_nxt   = rsp_err;
      case (state)
         IDLE: begin
            if (!empty) begin
               // The core never terminates on a zero operand, so answer these here.
               if (head.x == '0 || head.y == '0) begin
                  d_nxt     = head.x | head.y;
                  err_nxt   = 1'b0;
                  state_nxt = RESP;
               end else begin
                  x_nxt     = head.x;
                  y_nxt     = head.y;
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_nxt   = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            cnt_nxt = cnt + CW'(1);
            if (done_i) begin
               d_nxt     = d_i;
               err_nxt   = 1'b0;
               state_nxt = RESP;
            end else if (cnt == LAST_WAIT) begin
               d_nxt     = '0;
               err_nxt   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         go_o      <= 1'b0;
         x_o       <= '0;
         y_o       <= '0;
         rsp_valid <= 1'b0;
         rsp_d     <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         go_o      <= (state_nxt == ISSUE);
         x_o       <= x_nxt;
         y_o       <= y_nxt;
         rsp_valid <= (state_nxt == RESP);
         rsp_d     <= d_nxt;
         rsp_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: directed scenarios plus random batches against a GCD scoreboard and a delay-programmable core model.
module tb_gcd_requester;
   localparam int W  = 4;
   localparam int TO = 64;

   typedef struct packed {
      logic [W-1:0] d;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_x;
   logic [W-1:0] req_y;
   logic         go_o;
   logic [W-1:0] x_o;
   logic [W-1:0] y_o;
   logic         done_i;
   logic [W-1:0] d_i;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_d;
   logic         rsp_err;
   logic         busy;

   gcd_requester #(.WIDTH(W), .DEPTH(4), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .go_o(go_o), .x_o(x_o), .y_o(y_o),
      .done_i(done_i), .d_i(d_i), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_d(rsp_d), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int             n_chk = 0;
   int             n_pass = 0;
   int             n_go = 0;
   exp_t           exp_q[$];
   logic [2*W-1:0] ops_q[$];
   bit             last_acc = 0;
   bit             prev_go = 0;
   int             core_lat = 5;
   int             core_lat_act = 0;
   int             core_cnt = 0;
   bit             core_pending = 0;
   logic [W-1:0]   core_x = '0;
   logic [W-1:0]   core_y = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      else n_pass++;
   endtask

   function automatic int unsigned gcd_ref(input int unsigned a_in, input int unsigned b_in);
      int unsigned a = a_in;
      int unsigned b = b_in;
      int unsigned t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // A core that answers within TIMEOUT WAIT cycles is a normal result; otherwise an error with d=0.
   function automatic exp_t expect_rsp(input logic [W-1:0] x, input logic [W-1:0] y, input int lat);
      exp_t e;
      if (x == '0 || y == '0 || (lat >= 1 && lat <= TO)) begin
         e.d   = W'(gcd_ref(32'(x), 32'(y)));
         e.err = 1'b0;
      end else begin
         e.d   = '0;
         e.err = 1'b1;
      end
      return e;
   endfunction

   task automatic tick();
      bit             acc;
      bit             hs;
      logic [W-1:0]   ax;
      logic [W-1:0]   ay;
      logic [2*W-1:0] h;
      exp_t           e;
      acc = !rst && req_valid && req_ready;
      hs  = !rst && rsp_valid && rsp_ready;
      ax  = req_x;
      ay  = req_y;
      if (hs) begin
         if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            void'(ops_q.pop_front());
            chk("rsp_d", 32'(rsp_d), 32'(e.d));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
         end
      end
      @(posedge clk);
      #1;
      last_acc = acc;
      if (acc) begin
         exp_q.push_back(expect_rsp(ax, ay, core_lat));
         ops_q.push_back({ax, ay});
      end
      done_i = 1'b0;
      if (go_o) begin
         n_go++;
         chk("go_width", 32'(prev_go), 0);
         if (ops_q.size() == 0) chk("go_no_req", 1, 0);
         else begin
            h = ops_q[0];
            chk("go_x", 32'(x_o), 32'(h[2*W-1:W]));
            chk("go_y", 32'(y_o), 32'(h[W-1:0]));
            chk("go_nonzero", 32'(x_o == '0 || y_o == '0), 0);
         end
         core_x       = x_o;
         core_y       = y_o;
         core_pending = 1;
         core_cnt     = 0;
         core_lat_act = core_lat;
      end else if (core_pending) begin
         chk("hold_x", 32'(x_o), 32'(core_x));
         chk("hold_y", 32'(y_o), 32'(core_y));
         core_cnt++;
         if (core_lat_act != 0 && core_cnt == core_lat_act) begin
            done_i       = 1'b1;
            d_i          = W'(gcd_ref(32'(core_x), 32'(core_y)));
            core_pending = 0;
         end else if (core_cnt > TO + 4) begin
            core_pending = 0;
         end
      end
      prev_go = go_o;
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
      int k = 0;
      req_valid = 1'b1;
      req_x     = x;
      req_y     = y;
      do begin
         tick();
         k++;
      end while (!last_acc && k < 300);
      req_valid = 1'b0;
      chk("send_accepted", 32'(last_acc), 1);
   endtask

   task automatic wait_idle(input int budget, input bit rnd);
      int k = 0;
      while ((busy || exp_q.size() != 0) && k < budget) begin
         if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
         k++;
      end
      rsp_ready = 1'b1;
      chk("idle_in_budget", 32'(k < budget), 1);
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      core_x = '0;
      core_y = '0;
      exp_q.delete();
      ops_q.delete();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int           rise;
      int           bad;
      int           g0;
      int           r;
      int           nb;
      logic [W-1:0] rx;
      logic [W-1:0] ry;

      req_valid = 1'b0;
      req_x     = '0;
      req_y     = '0;
      done_i    = 1'b0;
      d_i       = '0;
      rsp_ready = 1'b1;
      do_reset();
      do_reset();
      chk("rst_go", 32'(go_o), 0);
      chk("rst_x", 32'(x_o), 0);
      chk("rst_y", 32'(y_o), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_d", 32'(rsp_d), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_req_ready", 32'(req_ready), 1);

      // Basic request: done on the 5th WAIT cycle.
      core_lat = 5;
      send(4'd12, 4'd8);
      chk("t1_go_early", 32'(go_o), 0);
      tick();
      chk("t1_go", 32'(go_o), 1);
      chk("t1_x", 32'(x_o), 12);
      chk("t1_y", 32'(y_o), 8);
      tick();
      chk("t1_go_drop", 32'(go_o), 0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("t1_rsp_lat", 32'(rsp_valid), 32'(k == 5));
      end
      chk("t1_rsp_d", 32'(rsp_d), 4);
      chk("t1_rsp_err", 32'(rsp_err), 0);
      wait_idle(200, 0);

      // Zero operands are answered locally, one cycle after reaching the head.
      g0 = n_go;
      send(4'd0, 4'd9);
      chk("t2_rsp_not_yet", 32'(rsp_valid), 0);
      send(4'd0, 4'd0);
      chk("t2_rsp1_valid", 32'(rsp_valid), 1);
      chk("t2_rsp1_d", 32'(rsp_d), 9);
      tick();
      chk("t2_gap", 32'(rsp_valid), 0);
      tick();
      chk("t2_rsp2_valid", 32'(rsp_valid), 1);
      chk("t2_rsp2_d", 32'(rsp_d), 0);
      wait_idle(200, 0);
      chk("t2_no_go", 32'(n_go - g0), 0);

      // Backpressure, then pop and push colliding on a full queue.
      core_lat  = 3;
      rsp_ready = 1'b0;
      send(4'd6, 4'd4);
      send(4'd9, 4'd3);
      send(4'd7, 4'd7);
      send(4'd15, 4'd10);
      chk("t3_full", 32'(req_ready), 0);
      req_valid = 1'b1;
      req_x     = 4'd8;
      req_y     = 4'd12;
      bad       = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         bad += int'(last_acc);
      end
      chk("t3_stall", 32'(bad), 0);
      chk("t3_head_rsp", 32'(rsp_valid), 1);
      chk("t3_head_d", 32'(rsp_d), 2);
      rsp_ready = 1'b1;
      tick();
      chk("t6_push_refused", 32'(last_acc), 0);
      chk("t6_ready_after_pop", 32'(req_ready), 1);
      tick();
      chk("t6_push_taken", 32'(last_acc), 1);
      req_valid = 1'b0;
      wait_idle(500, 0);

      // Timeout after exactly TO WAIT cycles, late strobe ignored.
      core_lat  = 0;
      rsp_ready = 1'b0;
      send(4'd5, 4'd10);
      rise = 0;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (rise == 0 && rsp_valid) rise = k;
      end
      chk("t4_timeout_lat", 32'(rise), 32'(TO + 2));
      chk("t4_err", 32'(rsp_err), 1);
      chk("t4_d", 32'(rsp_d), 0);
      rsp_ready = 1'b1;
      tick();
      tick();
      tick();
      done_i = 1'b1;
      d_i    = 4'd5;
      tick();
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (rsp_valid || busy) bad++;
      end
      chk("t4_late_done_ignored", 32'(bad), 0);
      core_lat = 4;
      send(4'd9, 4'd6);
      wait_idle(200, 0);
      core_lat = TO;
      send(4'd14, 4'd7);
      wait_idle(200, 0);
      core_lat = TO + 1;
      send(4'd3, 4'd5);
      wait_idle(200, 0);

      // Reset in WAIT with two entries queued behind the active one.
      core_lat = 20;
      send(4'd12, 4'd9);
      send(4'd4, 4'd6);
      send(4'd10, 4'd5);
      tick();
      tick();
      tick();
      chk("t5_busy_before", 32'(busy), 1);
      do_reset();
      chk("t5_go", 32'(go_o), 0);
      chk("t5_rsp_valid", 32'(rsp_valid), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_req_ready", 32'(req_ready), 1);
      bad = 0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (rsp_valid || busy) bad++;
      end
      chk("t5_no_rsp_after_rst", 32'(bad), 0);

      for (int b = 0; b < 30; b++) begin
         r = $urandom_range(0, 9);
         if (r == 0) core_lat = ($urandom_range(0, 1) == 1) ? 0 : TO + 1;
         else if (r == 1) core_lat = TO;
         else core_lat = $urandom_range(1, 8);
         nb = $urandom_range(1, 4);
         for (int i = 0; i < nb; i++) begin
            rx = W'($urandom_range(0, 15));
            ry = W'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 1) == 1);
            send(rx, ry);
         end
         wait_idle(1500, 1);
      end

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
